// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries with flush; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_t    data_i,
    input  logic            pop_i,
    output fetch_entry_t    data_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [AddrW-1:0] wptr_q, wptr_d;
    logic [AddrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == CntW'(DEPTH));
        data_o  = mem_q[rptr_q];
        count_o = count_q;
    end

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = data_i;
                wptr_d        = wptr_q + AddrW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + AddrW'(1);
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word-aligned requests, buffers in-order responses, hands
// {pc, inst} pairs to decode, and supports redirects that discard in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CntW-1:0] fifo_count, occupancy;
    logic            fifo_empty, fifo_full;
    logic            req_fire, push, pop;
    logic [31:0]     redirect_pc_aligned;
    fetch_entry_t    push_entry, head_entry;

    always_comb begin
        redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
        out_valid           = !fifo_empty && !redirect_valid;
        pop                 = out_valid && out_ready;
        // Credit counts the slot freed by this cycle's pop so a zero-wait memory streams
        // one instruction per cycle.
        occupancy           = outstanding_q + fifo_count - CntW'(pop);
        imem_req_valid      = rst_n && !redirect_valid && (occupancy < DepthCnt);
        imem_req_addr       = pc_q;
        req_fire            = imem_req_valid && imem_req_ready;
        push                = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
        push_entry          = '{pc: rsp_pc_q, inst: imem_rsp_data};
        out_inst            = head_entry.inst;
        out_pc              = head_entry.pc;
    end

    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
        if (redirect_valid) begin
            pc_d       = redirect_pc_aligned;
            rsp_pc_d   = redirect_pc_aligned;
            // Everything still in flight after this cycle belongs to the old stream.
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CntW'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    rsp_with_credit_a: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding_q != '0));

    push_never_full_a: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned lat      = 1;

    logic [31:0] mq_addr [$];
    int unsigned mq_due  [$];

    logic        s_req_valid, s_out_valid;
    logic [31:0] s_req_addr, s_out_pc, s_out_inst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mq_addr.delete();
        mq_due.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // One clock: present any due response, sample at the falling edge, advance.
    task automatic step();
        if (mq_addr.size() > 0 && mq_due[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_addr.pop_front();
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_inst  = out_inst;
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] first_req, first_out_pc, first_out_inst, first_out_cyc;
        int unsigned req_count;

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #2;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);

        // Zero-wait streaming
        do_reset();
        lat = 1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t1_req_valid", 32'(s_req_valid), 32'd1);
            check("t1_req_addr", s_req_addr, 32'(4 * k));
            if (k < 2) begin
                check("t1_fill_out_valid", 32'(s_out_valid), 32'd0);
            end else begin
                check("t1_out_valid", 32'(s_out_valid), 32'd1);
                check("t1_out_pc", s_out_pc, 32'(4 * (k - 2)));
                check("t1_out_inst", s_out_inst, 32'(4 * (k - 2)));
            end
        end

        // Back-pressure from decode
        do_reset();
        lat = 1;
        out_ready = 1'b0;
        req_count = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_req_valid) req_count++;
        end
        check("t2_req_count", 32'(req_count), 32'd2);
        check("t2_req_stalled", 32'(s_req_valid), 32'd0);
        out_ready = 1'b1;
        step();
        check("t2_out_pc0", s_out_pc, 32'd0);
        check("t2_resume_addr", s_req_addr, 32'd8);
        step();
        check("t2_out_pc4", s_out_pc, 32'd4);
        step();
        check("t2_out_pc8", s_out_pc, 32'd8);

        // Redirect with two late responses in flight
        do_reset();
        lat = 3;
        out_ready = 1'b1;
        step();
        step();
        check("t3_second_req", s_req_addr, 32'd4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        check("t3_redir_req_valid", 32'(s_req_valid), 32'd0);
        redirect_valid = 1'b0;
        first_req      = 32'hFFFF_FFFF;
        first_out_pc   = 32'hFFFF_FFFF;
        first_out_inst = 32'hFFFF_FFFF;
        first_out_cyc  = 32'hFFFF_FFFF;
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_req_valid && first_req == 32'hFFFF_FFFF) first_req = s_req_addr;
            if (s_out_valid && first_out_pc == 32'hFFFF_FFFF) begin
                first_out_pc   = s_out_pc;
                first_out_inst = s_out_inst;
                first_out_cyc  = 32'(cyc - 1);
            end
        end
        check("t3_first_req", first_req, 32'h0000_0100);
        check("t3_first_out_pc", first_out_pc, 32'h0000_0100);
        check("t3_first_out_inst", first_out_inst, 32'h0000_0100);
        check("t3_first_out_cycle", first_out_cyc, 32'd8);

        // Redirect coinciding with a response and a pending output
        do_reset();
        lat = 1;
        out_ready = 1'b0;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        check("t4_redir_out_valid", 32'(s_out_valid), 32'd0);
        check("t4_redir_req_valid", 32'(s_req_valid), 32'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        check("t4_flushed_out_valid", 32'(s_out_valid), 32'd0);
        check("t4_new_req_addr", s_req_addr, 32'h0000_0200);
        step();
        check("t4_wait_out_valid", 32'(s_out_valid), 32'd0);
        step();
        check("t4_out_pc", s_out_pc, 32'h0000_0200);
        check("t4_out_inst", s_out_inst, 32'h0000_0200);
        step();
        check("t4_out_pc_next", s_out_pc, 32'h0000_0204);

        // PC wrap at the top of the address space
        do_reset();
        lat = 1;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        check("t5_redir_req_valid", 32'(s_req_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        check("t5_req_fff8", s_req_addr, 32'hFFFF_FFF8);
        step();
        check("t5_req_fffc", s_req_addr, 32'hFFFF_FFFC);
        step();
        check("t5_req_wrap", s_req_addr, 32'h0000_0000);
        check("t5_out_fff8", s_out_pc, 32'hFFFF_FFF8);
        step();
        check("t5_out_fffc", s_out_pc, 32'hFFFF_FFFC);
        step();
        check("t5_out_wrap", s_out_pc, 32'h0000_0000);
        check("t5_out_wrap_valid", 32'(s_out_valid), 32'd1);

        // Asynchronous reset mid-stream
        do_reset();
        lat = 1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("t6_pre_out_valid", 32'(s_out_valid), 32'd1);
        check("t6_pre_out_pc", s_out_pc, 32'd4);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_out_inst", out_inst, 32'd0);
        check("t6_rst_out_pc", out_pc, 32'd0);
        do_reset();
        step();
        check("t6_restart_addr", s_req_addr, 32'd0);
        step();
        step();
        check("t6_restart_out_pc", s_out_pc, 32'd0);
        check("t6_restart_out_valid", 32'(s_out_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
